fifo_block_reader: RTL and testbench

FIFO_BLOCK_READER -- requirements
Module: fifo_block_reader

---
 rtl/fifo_block_reader.sv | 129 ++++++++++++
 tb/tb_fifo_block_reader.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/fifo_block_reader.sv
// Reads one block of len_m1+1 words from an async FIFO's read side and
// presents them on a valid/ready output stage with a last-word flag.
module fifo_block_reader #(
  parameter int W  = 16,
  parameter int LW = 9
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [LW-1:0] len_m1,
  input  logic          abort,
  output logic          busy,
  output logic          done,
  output logic          aborted,
  input  logic          fifo_ready,
  input  logic [W-1:0]  fifo_data,
  output logic          fifo_trigger,
  output logic          out_valid,
  output logic [W-1:0]  out_data,
  output logic          out_last,
  input  logic          out_ready,
  output logic [15:0]   underrun_count
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_t;

  localparam logic [LW:0] REM_ONE = (LW+1)'(1);

  state_t        state_q, state_d;
  logic [LW:0]   rem_q, rem_d;
  logic          vld_q, vld_d;
  logic [W-1:0]  data_q, data_d;
  logic          last_q, last_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          abrt_q, abrt_d;
  logic [15:0]   ur_q, ur_d;

  logic can_emit, xfer, rem_nz, pop;

  assign can_emit = !vld_q || out_ready;
  assign xfer     = vld_q && out_ready;
  assign rem_nz   = (rem_q != '0);
  // Pop is gated by rst and abort so no word leaves the FIFO on those cycles.
  assign pop      = (state_q == S_RUN) && rem_nz && fifo_ready && can_emit && !abort && !rst;

  assign fifo_trigger   = pop;
  assign busy           = busy_q;
  assign done           = done_q;
  assign aborted        = abrt_q;
  assign out_valid      = vld_q;
  assign out_data       = data_q;
  assign out_last       = last_q;
  assign underrun_count = ur_q;

  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    vld_d   = vld_q;
    data_d  = data_q;
    last_d  = last_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    abrt_d  = 1'b0;
    ur_d    = ur_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          rem_d   = {1'b0, len_m1} + REM_ONE;
          ur_d    = '0;
          busy_d  = 1'b1;
          state_d = S_RUN;
        end
      end
      default: begin
        if (state_q == S_RUN && rem_nz && !fifo_ready && can_emit && ur_q != 16'hFFFF)
          ur_d = ur_q + 16'd1;
        if (abort) begin
          vld_d   = 1'b0;
          last_d  = 1'b0;
          busy_d  = 1'b0;
          abrt_d  = 1'b1;
          rem_d   = '0;
          state_d = S_IDLE;
        end else if (pop) begin
          data_d = fifo_data;
          vld_d  = 1'b1;
          last_d = (rem_q == REM_ONE);
          rem_d  = rem_q - REM_ONE;
          if (rem_q == REM_ONE) state_d = S_DRAIN;
        end else if (xfer) begin
          vld_d = 1'b0;
          // In DRAIN the only word that can be accepted is the flagged last one.
          if (state_q == S_DRAIN) begin
            last_d  = 1'b0;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            state_d = S_IDLE;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      rem_q   <= '0;
      vld_q   <= 1'b0;
      data_q  <= '0;
      last_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      abrt_q  <= 1'b0;
      ur_q    <= '0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      vld_q   <= vld_d;
      data_q  <= data_d;
      last_q  <= last_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      abrt_q  <= abrt_d;
      ur_q    <= ur_d;
    end
  end

endmodule

// File: tb/tb_fifo_block_reader.sv
// Directed and randomized checks of fifo_block_reader against a block-level
// reference model fed by a behavioural FIFO.
module tb_fifo_block_reader;
  localparam int W = 16, LW = 9, DEPTH = 4096;

  logic clk = 1'b0;
  logic rst, start, abort, out_ready;
  logic [LW-1:0] len_m1;
  logic busy, done, aborted, fifo_ready, fifo_trigger, out_valid, out_last;
  logic [W-1:0] fifo_data, out_data;
  logic [15:0] underrun_count;

  always #5 clk = ~clk;

  fifo_block_reader #(.W(W), .LW(LW)) dut (
    .clk(clk), .rst(rst), .start(start), .len_m1(len_m1), .abort(abort),
    .busy(busy), .done(done), .aborted(aborted),
    .fifo_ready(fifo_ready), .fifo_data(fifo_data), .fifo_trigger(fifo_trigger),
    .out_valid(out_valid), .out_data(out_data), .out_last(out_last),
    .out_ready(out_ready), .underrun_count(underrun_count));

  // Behavioural upstream FIFO: pops on a clock edge with trigger and ready high.
  logic [W-1:0] mem [DEPTH];
  int unsigned rd_ptr = 0, wr_ptr = 0;
  assign fifo_ready = (wr_ptr != rd_ptr);
  assign fifo_data  = mem[12'(rd_ptr)];
  always @(posedge clk) if (fifo_trigger && fifo_ready) rd_ptr <= rd_ptr + 1;

  // Block-level reference: word k of a block is the k-th FIFO entry from block start.
  int n_chk = 0, n_fail = 0;
  bit m_busy = 0, m_done = 0, m_abrt = 0;
  logic [15:0] m_ur = '0;
  int m_len = 0, m_base = 0, m_k = 0;
  int tick_no = 0, first_x = 0, last_x = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [W-1:0] v);
    mem[12'(wr_ptr)] = v;
    wr_ptr++;
  endtask

  task automatic tick();
    bit xfer, hold, r;
    logic [W-1:0] hd;
    logic hl;
    int pops;
    #1;
    m_done = 0;
    m_abrt = 0;
    r    = rst;
    xfer = out_valid && out_ready;
    hold = out_valid && !out_ready && !rst && !abort;
    hd   = out_data;
    hl   = out_last;
    chk("trig_without_ready", fifo_trigger && !fifo_ready, 0);
    if (r) chk("trig_in_rst", fifo_trigger, 0);
    if (hold) chk("trig_in_stall", fifo_trigger, 0);
    if (r) begin
      m_busy = 0;
      m_ur   = '0;
    end else if (!m_busy) begin
      chk("idle_valid", out_valid, 0);
      if (start) begin
        m_busy = 1; m_len = len_m1 + 1; m_base = rd_ptr; m_k = 0; m_ur = '0;
      end
    end else begin
      pops = rd_ptr - m_base;
      chk("pop_bound", pops <= m_len, 1);
      if (pops < m_len && !fifo_ready && (!out_valid || out_ready) && m_ur != 16'hFFFF)
        m_ur++;
      if (abort) begin
        m_busy = 0;
        m_abrt = 1;
      end else if (xfer) begin
        chk("word", out_data, mem[12'(m_base + m_k)]);
        chk("last", out_last, m_k == m_len - 1);
        if (m_k == 0) first_x = tick_no;
        last_x = tick_no;
        m_k++;
        if (m_k == m_len) begin m_busy = 0; m_done = 1; end
      end
    end
    @(posedge clk);
    @(negedge clk);
    tick_no++;
    chk("busy", busy, m_busy);
    chk("done", done, m_done);
    chk("aborted", aborted, m_abrt);
    chk("underrun", underrun_count, m_ur);
    if (r) begin
      chk("rst_valid", out_valid, 0);
      chk("rst_last", out_last, 0);
      chk("rst_data", out_data, 0);
    end
    if (m_abrt) begin
      chk("abort_valid", out_valid, 0);
      chk("abort_last", out_last, 0);
    end
    if (hold) begin
      chk("hold_valid", out_valid, 1);
      chk("hold_data", out_data, hd);
      chk("hold_last", out_last, hl);
    end
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while (m_busy && n < budget) begin tick(); n++; end
    chk("timeout", m_busy, 0);
  endtask

  initial begin
    rst = 1; start = 0; abort = 0; out_ready = 1; len_m1 = '0;
    #1;
    // Reset
    tick(); tick();
    rst = 0;
    tick();

    // Four words back-to-back
    push(16'h000A); push(16'h000B); push(16'h000C); push(16'h000D);
    start = 1; len_m1 = 9'd3; tick(); start = 0;
    wait_idle(20);
    chk("b2b_span", last_x - first_x, 3);
    chk("b2b_count", m_k, 4);
    chk("b2b_underrun", underrun_count, 0);
    tick();

    // Starvation: two words, third after five empty cycles
    push(16'h1111); push(16'h2222);
    start = 1; len_m1 = 9'd3; tick(); start = 0;
    tick(); tick();
    repeat (5) tick();
    push(16'h3333); push(16'h4444);
    wait_idle(20);
    chk("starve_underrun", underrun_count, 5);
    chk("starve_count", m_k, 4);

    // Downstream backpressure mid-block
    for (int i = 0; i < 8; i++) push(16'h5000 + 16'(i));
    start = 1; len_m1 = 9'd7; tick(); start = 0;
    repeat (3) tick();
    out_ready = 0;
    repeat (3) tick();
    out_ready = 1;
    wait_idle(30);
    chk("bp_count", m_k, 8);

    // Abort two cycles after start; leftovers consumed by the next block
    for (int i = 0; i < 10; i++) push(16'h6000 + 16'(i));
    start = 1; len_m1 = 9'd7; tick(); start = 0;
    tick();
    abort = 1; tick(); abort = 0;
    chk("abort_busy", busy, 0);
    start = 1; abort = 1; len_m1 = 9'd1; tick(); start = 0; abort = 0;
    wait_idle(20);
    chk("post_abort_count", m_k, 2);

    // Single-word block, start while busy ignored
    push(16'h7777);
    start = 1; len_m1 = 9'd0; tick();
    len_m1 = 9'd5; tick(); start = 0;
    wait_idle(20);
    chk("single_count", m_k, 1);

    // Reset while draining the last word
    for (int i = 0; i < 4; i++) push(16'h8000 + 16'(i));
    start = 1; len_m1 = 9'd3; tick(); start = 0;
    for (int n = 0; n < 20 && (rd_ptr - m_base) < m_len; n++) tick();
    out_ready = 0; tick();
    rst = 1; tick(); rst = 0;
    chk("drain_rst_busy", busy, 0);
    out_ready = 1; tick();

    // Randomized traffic with occasional abort and start-while-busy
    repeat (3000) begin
      out_ready = ($urandom % 4) != 0;
      if ((wr_ptr - rd_ptr) < 40 && ($urandom % 2) == 1) push(W'($urandom));
      start  = ($urandom % 5) == 0;
      abort  = ($urandom % 60) == 0;
      len_m1 = LW'($urandom % 16);
      tick();
    end
    start = 0; abort = 0; out_ready = 1;
    for (int n = 0; n < 200 && m_busy; n++) begin
      if ((wr_ptr - rd_ptr) < 20) push(W'($urandom));
      tick();
    end
    chk("rand_idle", m_busy, 0);

    // Maximum block length
    for (int i = 0; i < 512; i++) push(W'($urandom));
    start = 1; len_m1 = '1; tick(); start = 0;
    wait_idle(1500);
    chk("max_count", m_k, 512);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule
